// File: rtl/mips_muldiv_pkg.sv
// Shared opcodes, FSM state encoding and fixed result constants for the
// MIPS multiply/divide unit.
package mips_muldiv_pkg;

    // Op field encoding as delivered by the decode stage
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Control FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIX   = 2'd2;

    // Quotient reported for a divide by zero
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_iter_unsigned.sv
// Unsigned 1-bit-per-cycle multiply/divide datapath.
// Multiply: shift-add on a {upper[WIDTH:0], multiplier[WIDTH-1:0]} accumulator.
// Divide:   restoring division on a {remainder[WIDTH:0], quotient[WIDTH-1:0]} accumulator.
module muldiv_iter_unsigned
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_div,
    input  logic             step,
    input  logic [WIDTH:0]   a_mag,
    input  logic [WIDTH:0]   b_mag,
    output logic [5:0]       count,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH:0] acc;
    logic [WIDTH:0]   m;        // multiplicand or divisor magnitude
    logic             div_mode;

    logic [WIDTH+1:0] mul_sum;
    logic [2*WIDTH:0] mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [2*WIDTH:0] div_next;

    // Next accumulator value for one multiply step and one divide step
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Remainder stays below the divisor, so its top bit is never needed in the shift
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {1'b0, m};
        if (div_trial[WIDTH+1]) begin
            div_next = {div_shift, acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Load operands on launch, then advance one step per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            m        <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            div_mode <= load_div;
            count    <= '0;
            if (load_div) begin
                m   <= b_mag;
                acc <= {{(WIDTH+1){1'b0}}, a_mag[WIDTH-1:0]};
            end else begin
                m   <= a_mag;
                acc <= {{(WIDTH+1){1'b0}}, b_mag[WIDTH-1:0]};
            end
        end else if (step) begin
            count <= count + 6'd1;
            acc   <= div_mode ? div_next : mul_next;
        end
    end

    assign res_hi = acc[2*WIDTH-1:WIDTH];
    assign res_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 33-cycle latency: 32 unsigned iteration steps plus one sign-fix cycle.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivByZero
);

    localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

    logic [1:0]       state;
    logic             div_q;
    logic             neg_res_q;   // product / quotient must be negated
    logic             neg_rem_q;   // remainder must be negated
    logic             div0_q;
    logic [WIDTH-1:0] a_raw_q;

    logic             is_signed;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   a_mag;
    logic [WIDTH:0]   b_mag;
    logic             accept;

    logic [5:0]         count;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept = (state == ST_IDLE) && Start;
    assign Busy   = (state == ST_RUN) || (state == ST_FIX);

    // Operand magnitudes; 33 bits so that |0x80000000| stays exact
    always_comb begin
        is_signed = ~Op[0];
        a_ext     = {is_signed & A[WIDTH-1], A};
        b_ext     = {is_signed & B[WIDTH-1], B};
        a_mag     = a_ext[WIDTH] ? -a_ext : a_ext;
        b_mag     = b_ext[WIDTH] ? -b_ext : b_ext;
    end

    // Sign correction of the unsigned result
    always_comb begin
        prod     = {res_hi, res_lo};
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -res_lo : res_lo;
        rem_fix  = neg_rem_q ? -res_hi : res_hi;
    end

    muldiv_iter_unsigned #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (Reset),
        .load     (accept),
        .load_div (Op[1]),
        .step     (state == ST_RUN),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .count    (count),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    // Control FSM, launch-time latches and HI/LO write-back
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_raw_q   <= '0;
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        div_q     <= Op[1];
                        neg_res_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_q <= is_signed & A[WIDTH-1];
                        div0_q    <= Op[1] & (B == '0);
                        a_raw_q   <= A;
                        DivByZero <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (count == LAST_COUNT) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    Done      <= 1'b1;
                    DivByZero <= div0_q;
                    state     <= ST_IDLE;
                    if (div0_q) begin
                        HI <= a_raw_q;
                        LO <= DIV0_QUOT;
                    end else if (div_q) begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
